// File: rtl/irs_multi_buffer_block_manager_if.sv
// Write-handshake and lock/free request bundle between the IRS block manager (master)
// and the write controller / trigger logic (slave).
interface irs_multi_buffer_block_manager_if #(
    parameter int NBLOCK_BITS = 9
);
    logic                   blk_en_o;
    logic [NBLOCK_BITS-1:0] blk_o;
    logic                   blk_ack_i;
    logic [NBLOCK_BITS-1:0] lock_address_i;
    logic                   lock_strobe_i;
    logic                   lock_ack_o;
    logic                   lock_err_o;
    logic [NBLOCK_BITS-1:0] free_address_i;
    logic                   free_strobe_i;
    logic                   free_ack_o;

    modport master (
        output blk_en_o, blk_o, lock_ack_o, lock_err_o, free_ack_o,
        input  blk_ack_i, lock_address_i, lock_strobe_i, free_address_i, free_strobe_i
    );

    modport slave (
        input  blk_en_o, blk_o, lock_ack_o, lock_err_o, free_ack_o,
        output blk_ack_i, lock_address_i, lock_strobe_i, free_address_i, free_strobe_i
    );
endinterface

// File: rtl/irs_multi_buffer_block_manager.sv
// IRS block manager: hands logical blocks to the write controller and skips any block
// held in a small table of blocks locked for readout.
module irs_multi_buffer_block_manager #(
    parameter int NBLOCK_BITS = 9,
    parameter int NLOCK       = 4,
    parameter int NLOCK_BITS  = 3
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   en_i,
    irs_multi_buffer_block_manager_if.master bus,
    input  logic                   ped_mode_i,
    input  logic [NBLOCK_BITS-1:0] ped_address_i,
    output logic                   ped_ack_o,
    output logic                   dead_o,
    input  logic                   dead_clear_i,
    output logic [NLOCK_BITS-1:0]  nlocked_o,
    output logic [15:0]            debug_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ADVANCE = 2'd1,
        ISSUE   = 2'd2
    } state_t;

    localparam logic [NBLOCK_BITS-1:0] BLK_ONE   = NBLOCK_BITS'(1);
    localparam logic [NLOCK_BITS-1:0]  NLOCK_MAX = NLOCK_BITS'(NLOCK);

    state_t                 state_q, state_d;
    logic [NBLOCK_BITS-1:0] cand_q, cand_d;
    logic [NBLOCK_BITS-1:0] blk_q, blk_d;
    logic                   blk_en_q, blk_en_d;
    logic                   ped_ack_q, ped_ack_d;

    logic [NLOCK-1:0]       valid_q, valid_d, valid_free;
    logic [NBLOCK_BITS-1:0] addr_q [NLOCK];
    logic [NBLOCK_BITS-1:0] addr_d [NLOCK];
    logic                   lock_ack_q, lock_err_q, lock_err_d, free_ack_q;
    logic                   lock_dup, lock_full, lock_placed;
    logic                   overflow_q, overflow_d;
    logic [NLOCK_BITS-1:0]  nlocked_q, nlocked_d;
    logic                   dead_q;
    logic                   cand_locked;

    // Free is resolved against the registered table before the lock is considered, so a
    // same-cycle free can open the slot a lock needs.
    always_comb begin
        valid_free = valid_q;
        if (bus.free_strobe_i) begin
            for (int i = 0; i < NLOCK; i++) begin
                if (valid_q[i] && addr_q[i] == bus.free_address_i) valid_free[i] = 1'b0;
            end
        end
    end

    // NOTE: every signal written in an always_comb gets a default first, otherwise any
    // path that skips an assignment infers a latch.
    always_comb begin
        valid_d     = valid_free;
        addr_d      = addr_q;
        lock_dup    = 1'b0;
        lock_placed = 1'b0;
        for (int i = 0; i < NLOCK; i++) begin
            if (valid_free[i] && addr_q[i] == bus.lock_address_i) lock_dup = 1'b1;
        end
        lock_full  = &valid_free;
        lock_err_d = bus.lock_strobe_i && !lock_dup && lock_full;
        if (bus.lock_strobe_i && !lock_dup) begin
            for (int i = 0; i < NLOCK; i++) begin
                if (!lock_placed && !valid_free[i]) begin
                    valid_d[i]  = 1'b1;
                    addr_d[i]   = bus.lock_address_i;
                    lock_placed = 1'b1;
                end
            end
        end
        overflow_d = (overflow_q && !dead_clear_i) || lock_err_d;
        nlocked_d  = '0;
        for (int i = 0; i < NLOCK; i++) nlocked_d = nlocked_d + NLOCK_BITS'(valid_q[i]);
    end

    // At most NLOCK consecutive blocks can be locked, so the search ends within NLOCK+1 cycles.
    always_comb begin
        cand_locked = 1'b0;
        for (int i = 0; i < NLOCK; i++) begin
            if (valid_q[i] && addr_q[i] == cand_q) cand_locked = 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples the
    // pre-edge value of every other flop, independent of statement order.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            valid_q    <= '0;
            lock_ack_q <= 1'b0;
            lock_err_q <= 1'b0;
            free_ack_q <= 1'b0;
            overflow_q <= 1'b0;
            nlocked_q  <= '0;
            dead_q     <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            lock_ack_q <= bus.lock_strobe_i;
            lock_err_q <= lock_err_d;
            free_ack_q <= bus.free_strobe_i;
            overflow_q <= overflow_d;
            nlocked_q  <= nlocked_d;
            dead_q     <= (nlocked_d == NLOCK_MAX) || overflow_q;
        end
    end

    // NOTE: entry addresses are left unreset; an entry means nothing until its valid bit
    // is set, and that bit is reset.
    always_ff @(posedge clk_i) begin
        addr_q <= addr_d;
    end

    always_comb begin
        state_d   = state_q;
        cand_d    = cand_q;
        blk_d     = blk_q;
        blk_en_d  = blk_en_q;
        ped_ack_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (en_i) state_d = ADVANCE;
            end
            ADVANCE: begin
                if (ped_mode_i) begin
                    blk_d    = ped_address_i;
                    blk_en_d = 1'b1;
                    state_d  = ISSUE;
                end else if (cand_locked) begin
                    cand_d = cand_q + BLK_ONE;
                end else begin
                    blk_d    = cand_q;
                    blk_en_d = 1'b1;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                if (bus.blk_ack_i) begin
                    blk_en_d  = 1'b0;
                    cand_d    = blk_q + BLK_ONE;
                    ped_ack_d = ped_mode_i;
                    state_d   = en_i ? ADVANCE : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= IDLE;
            cand_q    <= '0;
            blk_q     <= '0;
            blk_en_q  <= 1'b0;
            ped_ack_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cand_q    <= cand_d;
            blk_q     <= blk_d;
            blk_en_q  <= blk_en_d;
            ped_ack_q <= ped_ack_d;
        end
    end

    logic [11:0] cand_dbg;
    if (NBLOCK_BITS >= 12) begin : g_dbg_trunc
        assign cand_dbg = cand_q[11:0];
    end else begin : g_dbg_ext
        assign cand_dbg = {{(12 - NBLOCK_BITS){1'b0}}, cand_q};
    end

    assign bus.blk_en_o   = blk_en_q;
    assign bus.blk_o      = blk_q;
    assign bus.lock_ack_o = lock_ack_q;
    assign bus.lock_err_o = lock_err_q;
    assign bus.free_ack_o = free_ack_q;
    assign ped_ack_o      = ped_ack_q;
    assign dead_o         = dead_q;
    assign nlocked_o      = nlocked_q;
    assign debug_o        = {cand_dbg, dead_q, blk_en_q, state_q};

endmodule

// File: tb/tb_irs_multi_buffer_block_manager.sv
// Bench for the IRS block manager: a set-based model checked every cycle, plus directed
// scenarios with literal expectations.
module tb_irs_multi_buffer_block_manager;
    localparam int NB  = 9;
    localparam int NL  = 4;
    localparam int NLB = 3;

    logic           clk;
    logic           rst_n;
    logic           en;
    logic           ped_mode;
    logic [NB-1:0]  ped_addr;
    logic           ped_ack;
    logic           dead;
    logic           dead_clear;
    logic [NLB-1:0] nlocked;
    logic [15:0]    debug;

    int checks   = 0;
    int failures = 0;

    irs_multi_buffer_block_manager_if #(.NBLOCK_BITS(NB)) bus_if ();

    irs_multi_buffer_block_manager #(
        .NBLOCK_BITS(NB), .NLOCK(NL), .NLOCK_BITS(NLB)
    ) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .en_i         (en),
        .bus          (bus_if.master),
        .ped_mode_i   (ped_mode),
        .ped_address_i(ped_addr),
        .ped_ack_o    (ped_ack),
        .dead_o       (dead),
        .dead_clear_i (dead_clear),
        .nlocked_o    (nlocked),
        .debug_o      (debug)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Model: the lock table is just a set of block numbers; the sequencer is described by
    // "waiting for en", "seeking from m_cand" and "offering m_blk".
    bit            locked [1 << NB];
    int            m_cnt;
    bit            m_ovf;
    bit            m_seek;
    logic          m_blk_en;
    logic [NB-1:0] m_blk, m_cand;
    logic          m_lock_ack, m_lock_err, m_free_ack, m_ped_ack, m_dead;
    int            m_nlocked;

    task automatic model_reset();
        foreach (locked[i]) locked[i] = 1'b0;
        m_cnt = 0; m_ovf = 0; m_seek = 0;
        m_blk_en = 0; m_blk = '0; m_cand = '0;
        m_lock_ack = 0; m_lock_err = 0; m_free_ack = 0; m_ped_ack = 0;
        m_dead = 0; m_nlocked = 0;
    endtask

    task automatic model_step();
        bit err;
        m_nlocked = m_cnt;
        m_dead    = (m_cnt == NL) || m_ovf;
        m_ped_ack = 1'b0;
        if (m_blk_en) begin
            if (bus_if.blk_ack_i) begin
                m_blk_en  = 1'b0;
                m_cand    = m_blk + 1'b1;
                m_ped_ack = ped_mode;
                m_seek    = en;
            end
        end else if (m_seek) begin
            if (ped_mode) begin
                m_blk = ped_addr; m_blk_en = 1'b1; m_seek = 1'b0;
            end else if (locked[m_cand]) begin
                m_cand = m_cand + 1'b1;
            end else begin
                m_blk = m_cand; m_blk_en = 1'b1; m_seek = 1'b0;
            end
        end else if (en) begin
            m_seek = 1'b1;
        end
        err = 1'b0;
        if (bus_if.free_strobe_i && locked[bus_if.free_address_i]) begin
            locked[bus_if.free_address_i] = 1'b0;
            m_cnt--;
        end
        if (bus_if.lock_strobe_i && !locked[bus_if.lock_address_i]) begin
            if (m_cnt == NL) err = 1'b1;
            else begin
                locked[bus_if.lock_address_i] = 1'b1;
                m_cnt++;
            end
        end
        m_lock_ack = bus_if.lock_strobe_i;
        m_free_ack = bus_if.free_strobe_i;
        m_lock_err = err;
        m_ovf      = (m_ovf && !dead_clear) || err;
    endtask

    always @(posedge clk) begin
        logic [1:0]  st;
        logic [15:0] exp_dbg;
        if (!rst_n) model_reset();
        else        model_step();
        #1;
        st      = m_blk_en ? 2'd2 : (m_seek ? 2'd1 : 2'd0);
        exp_dbg = {3'b000, m_cand, m_dead, m_blk_en, st};
        check("m_blk_en",   bus_if.blk_en_o,   m_blk_en);
        check("m_blk",      bus_if.blk_o,      m_blk);
        check("m_lock_ack", bus_if.lock_ack_o, m_lock_ack);
        check("m_lock_err", bus_if.lock_err_o, m_lock_err);
        check("m_free_ack", bus_if.free_ack_o, m_free_ack);
        check("m_ped_ack",  ped_ack,           m_ped_ack);
        check("m_nlocked",  nlocked,           m_nlocked);
        check("m_dead",     dead,              m_dead);
        check("m_debug",    debug,             exp_dbg);
    end

    // Stimulus tasks start and end on a falling edge.
    task automatic do_reset();
        en = 1'b0; ped_mode = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic pulse_lock(input logic [NB-1:0] a);
        bus_if.lock_address_i = a; bus_if.lock_strobe_i = 1'b1;
        @(negedge clk);
        bus_if.lock_strobe_i = 1'b0;
    endtask

    task automatic pulse_free(input logic [NB-1:0] a);
        bus_if.free_address_i = a; bus_if.free_strobe_i = 1'b1;
        @(negedge clk);
        bus_if.free_strobe_i = 1'b0;
    endtask

    task automatic pulse_both(input logic [NB-1:0] fa, input logic [NB-1:0] la);
        bus_if.free_address_i = fa; bus_if.free_strobe_i = 1'b1;
        bus_if.lock_address_i = la; bus_if.lock_strobe_i = 1'b1;
        @(negedge clk);
        bus_if.free_strobe_i = 1'b0; bus_if.lock_strobe_i = 1'b0;
    endtask

    task automatic wait_en(output int n);
        n = 0;
        while (bus_if.blk_en_o !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("blk_en_wait", bus_if.blk_en_o, 1'b1);
    endtask

    task automatic ack_write(input int hold, output logic [NB-1:0] b, output logic pa);
        repeat (hold) @(negedge clk);
        b = bus_if.blk_o;
        bus_if.blk_ack_i = 1'b1;
        @(negedge clk);
        bus_if.blk_ack_i = 1'b0;
        pa = ped_ack;
    endtask

    initial begin
        int            n;
        int            ped_cnt;
        logic [NB-1:0] b;
        logic          pa;
        logic [15:0]   dbg;
        rst_n = 1'b0; en = 1'b0; ped_mode = 1'b0; ped_addr = '0; dead_clear = 1'b0;
        bus_if.blk_ack_i = 1'b0;
        bus_if.lock_address_i = '0; bus_if.lock_strobe_i = 1'b0;
        bus_if.free_address_i = '0; bus_if.free_strobe_i = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check("rst_blk_en",  bus_if.blk_en_o, 0);
        check("rst_blk",     bus_if.blk_o, 0);
        check("rst_nlocked", nlocked, 0);
        check("rst_dead",    dead, 0);
        check("rst_debug",   debug, 0);

        // Normal sequencing across the wrap.
        en = 1'b1;
        wait_en(n);
        check("first_latency", n, 2);
        for (int i = 0; i < 514; i++) begin
            ack_write(2, b, pa);
            check("seq_blk", b, i % 512);
            if (i < 513) begin
                wait_en(n);
                check("seq_gap", n + 1, 2);
            end
        end

        // Skip locked blocks.
        do_reset();
        en = 1'b1;
        wait_en(n);
        for (int i = 0; i < 3; i++) begin
            ack_write(0, b, pa);
            wait_en(n);
        end
        check("skip_pre_blk", bus_if.blk_o, 3);
        pulse_lock(9'd5);
        check("skip_lock_ack", bus_if.lock_ack_o, 1);
        pulse_lock(9'd6);
        ack_write(0, b, pa);
        check("skip_w3", b, 3);
        wait_en(n);
        ack_write(0, b, pa);
        check("skip_w4", b, 4);
        wait_en(n);
        check("skip_gap", n + 1, 4);
        check("skip_blk", bus_if.blk_o, 7);
        check("skip_nlocked", nlocked, 2);
        en = 1'b0;
        ack_write(0, b, pa);

        // Full table and sticky overflow.
        do_reset();
        pulse_lock(9'd10); pulse_lock(9'd20); pulse_lock(9'd30); pulse_lock(9'd40);
        @(negedge clk);
        check("full_nlocked", nlocked, 4);
        check("full_dead", dead, 1);
        pulse_lock(9'd50);
        check("ovf_ack", bus_if.lock_ack_o, 1);
        check("ovf_err", bus_if.lock_err_o, 1);
        @(negedge clk);
        check("ovf_nlocked", nlocked, 4);
        pulse_free(9'd20);
        @(negedge clk);
        check("ovf_free_nlocked", nlocked, 3);
        check("ovf_sticky_dead", dead, 1);
        dead_clear = 1'b1;
        @(negedge clk);
        dead_clear = 1'b0;
        @(negedge clk);
        check("ovf_cleared_dead", dead, 0);

        // Duplicate, missing and simultaneous requests.
        do_reset();
        pulse_lock(9'd7); pulse_lock(9'd7);
        @(negedge clk);
        check("dup_nlocked", nlocked, 1);
        pulse_free(9'd99);
        check("miss_free_ack", bus_if.free_ack_o, 1);
        @(negedge clk);
        check("miss_nlocked", nlocked, 1);
        pulse_lock(9'd10); pulse_lock(9'd20); pulse_lock(9'd30);
        @(negedge clk);
        check("sim_full", nlocked, 4);
        pulse_both(9'd10, 9'd60);
        check("sim_lock_ack", bus_if.lock_ack_o, 1);
        check("sim_free_ack", bus_if.free_ack_o, 1);
        check("sim_lock_err", bus_if.lock_err_o, 0);
        @(negedge clk);
        check("sim_nlocked", nlocked, 4);
        pulse_both(9'd7, 9'd7);
        check("same_lock_err", bus_if.lock_err_o, 0);
        @(negedge clk);
        check("same_nlocked", nlocked, 4);
        pulse_free(9'd60);
        @(negedge clk);
        check("held60_nlocked", nlocked, 3);
        check("held60_dead", dead, 0);

        // Pedestal mode writes a locked block anyway.
        do_reset();
        pulse_lock(9'd77);
        ped_mode = 1'b1; ped_addr = 9'd77; en = 1'b1;
        ped_cnt = 0;
        wait_en(n);
        for (int i = 0; i < 3; i++) begin
            if (i == 2) en = 1'b0;
            ack_write(1, b, pa);
            check("ped_blk", b, 77);
            if (pa === 1'b1) ped_cnt++;
            if (i < 2) wait_en(n);
        end
        check("ped_ack_count", ped_cnt, 3);
        ped_mode = 1'b0;

        // Disable mid-write, resume, then reset mid-write.
        do_reset();
        en = 1'b1;
        wait_en(n);
        for (int i = 0; i < 12; i++) begin
            ack_write(0, b, pa);
            wait_en(n);
        end
        check("dis_pre_blk", bus_if.blk_o, 12);
        en = 1'b0;
        ack_write(1, b, pa);
        check("dis_w12", b, 12);
        repeat (2) @(negedge clk);
        dbg = debug;
        check("dis_blk_en", bus_if.blk_en_o, 0);
        check("dis_idle", dbg[1:0], 0);
        en = 1'b1;
        wait_en(n);
        check("resume_blk", bus_if.blk_o, 13);
        pulse_lock(9'd5);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_blk_en", bus_if.blk_en_o, 0);
        check("arst_blk", bus_if.blk_o, 0);
        check("arst_nlocked", nlocked, 0);
        @(negedge clk);
        en = 1'b0;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_nlocked", nlocked, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        failures++;
        $display("FAIL watchdog expired got=running expected=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/irs_multi_buffer_block_manager.md
Name: irs_multi_buffer_block_manager

Overview:
- Parametrised successor to the single-buffer IRS block manager.
- Hands logical block addresses to the IRS write controller over an enable/ack handshake.
- Keeps a table of up to NLOCK locked (pending-readout) blocks and skips locked blocks when advancing the write pointer, so sampling continues while several events await readout.
- Sits between the trigger/readout logic (lock/free) and the logical->physical block map / write controller.

Parameters:
- NBLOCK_BITS, 9: width of the block address; block space is 2^NBLOCK_BITS, wrapping.
- NLOCK, 4: number of lock-table entries. Legal range is 1 to 2^NBLOCK_BITS-2.
- NLOCK_BITS, 3: width of nlocked_o; must satisfy 2^NLOCK_BITS > NLOCK.

Ports:
- clk_i  in  1  system clock
- rst_n_i  in  1  asynchronous active-low reset
- en_i  in  1  general enable
- blk_en_o  out  1  request to write controller: write blk_o
- blk_o  out  NBLOCK_BITS  logical block to write
- blk_ack_i  in  1  write controller finished blk_o (1-cycle pulse)
- lock_address_i  in  NBLOCK_BITS  block to lock
- lock_strobe_i  in  1  1-cycle lock request
- lock_ack_o  out  1  1-cycle lock acknowledge
- lock_err_o  out  1  valid with lock_ack_o: table full, lock refused
- free_address_i  in  NBLOCK_BITS  block to free
- free_strobe_i  in  1  1-cycle free request
- free_ack_o  out  1  1-cycle free acknowledge
- ped_mode_i  in  1  pedestal mode: rewrite ped_address_i repeatedly
- ped_address_i  in  NBLOCK_BITS  pedestal block
- ped_ack_o  out  1  1-cycle pulse per completed pedestal write
- dead_o  out  1  lock table full, or sticky overflow set
- dead_clear_i  in  1  clears sticky overflow
- nlocked_o  out  NLOCK_BITS  count of valid lock entries
- debug_o  out  16  [1:0] state, [2] blk_en_o, [3] dead_o, [15:4] zero-extended/truncated cand

Behaviour:
- Reset (async, rst_n_i=0):
  - state=IDLE; blk_en_o=0, blk_o=0, cand=0.
  - All lock entries invalid; nlocked_o=0.
  - lock_ack_o, lock_err_o, free_ack_o, ped_ack_o all 0.
  - Sticky overflow=0; dead_o=0.
  - Reset mid-handshake abandons the write. The controller sees blk_en_o drop asynchronously.
- States:
  - IDLE: if en_i, go to ADVANCE.
  - ADVANCE, normal mode: cand is compared in parallel against all valid entries using the current registered table.
    - Cand not locked: blk_o<=cand, blk_en_o<=1, go to ISSUE.
    - Cand locked: cand<=cand+1, wrapping 2^NBLOCK_BITS-1 to 0; stay in ADVANCE.
    - The search is bounded at NLOCK+1 cycles.
  - ADVANCE, pedestal mode: blk_o<=ped_address_i, blk_en_o<=1, go to ISSUE. The lock table is ignored.
  - ISSUE: hold blk_en_o and blk_o until blk_ack_i. On the ack cycle:
    - blk_en_o<=0 and cand<=blk_o+1 (wrapping).
    - ped_ack_o<=1 for one cycle if ped_mode_i.
    - Next state is ADVANCE if en_i, else IDLE.
  - blk_ack_i outside ISSUE is ignored.
- Latency:
  - blk_en_o rises 2 cycles after en_i rises from IDLE.
  - blk_en_o rises again 2 cycles after each ack when no skip occurs; add 1 cycle per skipped locked block.
- Enable and mode changes:
  - en_i deasserted during ISSUE: the current write completes, then IDLE.
  - Re-enable resumes at the block after the last written block; there is no restart from 0.
  - ped_mode_i changes take effect at the next ADVANCE.
- Lock:
  - lock_ack_o pulses the cycle after lock_strobe_i.
  - Address already valid in the table: ack, no new entry, lock_err_o=0.
  - Table full: ack with lock_err_o=1 and sticky overflow set.
  - Otherwise the lowest-index invalid entry takes the address.
  - Locking the block currently in ISSUE is allowed. The write completes, and later ADVANCEs skip that block.
- Free:
  - free_ack_o pulses the cycle after free_strobe_i.
  - A matching valid entry is invalidated.
  - An address not in the table is acked with no change.
- Simultaneous lock and free in the same cycle:
  - The free is applied first, so a full table with a free of a valid address accepts the lock.
  - Both acks occur in the same cycle.
  - Freeing and locking the same address leaves it locked.
- Status outputs:
  - nlocked_o and dead_o are registered and track the table with 1-cycle latency.
  - dead_o = (nlocked_o==NLOCK) | overflow.
  - dead_clear_i clears overflow only. A full table keeps dead_o=1.

Test Plan:
- Normal sequencing: reset, en_i=1, ack every blk_en_o after 3 cycles, run 514 writes -> blk_o sequence is 0,1,...,511,0,1; first blk_en_o 2 cycles after en_i.
- Skip locked: lock 5 and 6 while writing block 3 -> after block 4 acks, blk_o=7 with blk_en_o 4 cycles after the ack; nlocked_o=2.
- Full table and overflow: lock 10,20,30,40 -> nlocked_o=4, dead_o=1. Lock 50 -> lock_err_o=1 and not added. Free 20 -> dead_o stays 1 due to overflow. dead_clear_i -> dead_o=0.
- Duplicate, missing and simultaneous requests:
  - Lock 7 twice -> nlocked_o=1.
  - Free 99, not locked -> free_ack_o=1, no change.
  - With a full table, same-cycle free of 10 and lock of 60 -> both acks; table holds 60; lock_err_o=0.
- Pedestal mode: ped_mode_i=1, ped_address_i=77, 3 acks -> blk_o=77 each time, 3 ped_ack_o pulses; a locked 77 is still written.
- Disable and reset: drop en_i during ISSUE of block 12 -> ack completes, state IDLE, blk_en_o=0; re-enable -> blk_o=13. Assert rst_n_i=0 mid-ISSUE -> blk_en_o=0 immediately, table cleared, blk_o=0.
